// File: rtl/lfu_pkg.sv
// lfu_tracker shared types and constants.
// Defaults are shared with the timer and the cache controller.
package lfu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam int DEF_ENTRIES = 8;
    localparam int DEF_IDX_W   = 3;
    localparam int DEF_CNT_W   = 8;

    function automatic logic [31:0] cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_inc(
        input logic [31:0] cnt,
        input logic [31:0] cmax
    );
        return (cnt >= cmax) ? cmax : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/lfu_counter.sv
// One saturating use counter.
// Fill wins outright; otherwise age first, then increment.
module lfu_counter
    import lfu_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             load_one,
    input  logic             age,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [31:0] CMAX = cnt_max(CNT_W);

    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] nxt;

    always_comb begin
        base = age ? (cnt >> 1) : cnt;
        nxt  = base;
        if (load_one) begin
            nxt = CNT_W'(1);
        end else if (inc) begin
            nxt = CNT_W'(sat_inc(32'(base), CMAX));
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= nxt;
        end
    end

endmodule

// File: rtl/lfu_tracker.sv
// Per-entry LFU counters with tick aging and a sequential
// victim scan for the cache controller.
module lfu_tracker
    import lfu_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int IDX_W   = DEF_IDX_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             tick,
    input  logic             hit_valid,
    input  logic [IDX_W-1:0] hit_idx,
    input  logic             fill_valid,
    input  logic [IDX_W-1:0] fill_idx,
    input  logic             victim_req,
    output logic             busy,
    output logic             victim_valid,
    output logic [IDX_W-1:0] victim_idx,
    output logic [CNT_W-1:0] victim_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(ENTRIES - 1);

    logic [CNT_W-1:0] cnt [ENTRIES];

    state_t           state, state_nxt;
    logic             age_pending;
    logic             aging_now;
    logic [IDX_W-1:0] scan_ptr, scan_ptr_nxt;
    logic [IDX_W-1:0] best_idx, best_idx_nxt;
    logic [CNT_W-1:0] best_cnt, best_cnt_nxt;
    logic             first, first_nxt;
    logic [IDX_W-1:0] victim_idx_nxt;
    logic [CNT_W-1:0] victim_cnt_nxt;
    logic [CNT_W-1:0] cur_cnt;

    // Aging is deferred out of a scan so results see one stable snapshot.
    assign aging_now = (tick || age_pending) && (state == IDLE);

    for (genvar i = 0; i < ENTRIES; i++) begin : g_cnt
        lfu_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clock    (clock),
            .rst      (rst),
            .load_one (fill_valid && (fill_idx == IDX_W'(i))),
            .age      (aging_now),
            .inc      (hit_valid && (hit_idx == IDX_W'(i))),
            .cnt      (cnt[i])
        );
    end

    assign cur_cnt = cnt[scan_ptr];

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            age_pending <= 1'b0;
        end else if (state == IDLE) begin
            age_pending <= 1'b0;
        end else if (tick) begin
            age_pending <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            scan_ptr   <= '0;
            best_idx   <= '0;
            best_cnt   <= '0;
            first      <= 1'b0;
            victim_idx <= '0;
            victim_cnt <= '0;
        end else begin
            state      <= state_nxt;
            scan_ptr   <= scan_ptr_nxt;
            best_idx   <= best_idx_nxt;
            best_cnt   <= best_cnt_nxt;
            first      <= first_nxt;
            victim_idx <= victim_idx_nxt;
            victim_cnt <= victim_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        scan_ptr_nxt   = scan_ptr;
        best_idx_nxt   = best_idx;
        best_cnt_nxt   = best_cnt;
        first_nxt      = first;
        victim_idx_nxt = victim_idx;
        victim_cnt_nxt = victim_cnt;
        busy           = 1'b0;
        victim_valid   = 1'b0;
        unique case (state)
            IDLE: begin
                if (victim_req) begin
                    state_nxt    = SCAN;
                    scan_ptr_nxt = '0;
                    best_idx_nxt = '0;
                    best_cnt_nxt = CNT_MAX;
                    first_nxt    = 1'b1;
                end
            end
            SCAN: begin
                busy = 1'b1;
                // Strict compare keeps the lower index on ties.
                if (first || (cur_cnt < best_cnt)) begin
                    best_idx_nxt = scan_ptr;
                    best_cnt_nxt = cur_cnt;
                end
                first_nxt    = 1'b0;
                scan_ptr_nxt = scan_ptr + IDX_W'(1);
                if (scan_ptr == LAST) begin
                    state_nxt      = DONE;
                    victim_idx_nxt = best_idx_nxt;
                    victim_cnt_nxt = best_cnt_nxt;
                end
            end
            DONE: begin
                victim_valid = 1'b1;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lfu_tracker.sv
// Directed self-checking bench for lfu_tracker.
// Expected values are hand-computed per step.
module tb_lfu_tracker;

    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       hit_valid = 1'b0;
    logic [2:0] hit_idx = '0;
    logic       fill_valid = 1'b0;
    logic [2:0] fill_idx = '0;
    logic       victim_req = 1'b0;
    logic       busy;
    logic       victim_valid;
    logic [2:0] victim_idx;
    logic [7:0] victim_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    lfu_tracker #(
        .ENTRIES (8),
        .IDX_W   (3),
        .CNT_W   (8)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .tick         (tick),
        .hit_valid    (hit_valid),
        .hit_idx      (hit_idx),
        .fill_valid   (fill_valid),
        .fill_idx     (fill_idx),
        .victim_req   (victim_req),
        .busy         (busy),
        .victim_valid (victim_valid),
        .victim_idx   (victim_idx),
        .victim_cnt   (victim_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        tick       = 1'b0;
        hit_valid  = 1'b0;
        fill_valid = 1'b0;
        victim_req = 1'b0;
    endtask

    task automatic hit(input int i, input int n);
        repeat (n) begin
            hit_valid = 1'b1;
            hit_idx   = 3'(i);
            cycle();
        end
        hit_valid = 1'b0;
    endtask

    task automatic fill(input int i);
        fill_valid = 1'b1;
        fill_idx   = 3'(i);
        cycle();
        fill_valid = 1'b0;
    endtask

    task automatic chk_cnt(input int i, input int exp);
        check($sformatf("cnt%0d", i), 32'(dut.cnt[i]), 32'(exp));
    endtask

    // mode 1: fills and two ticks mid-scan; mode 2: requests while busy
    task automatic scan(input int mode, input string tag,
                        input int eidx, input int ecnt);
        int n;
        victim_req = 1'b1;
        cycle();
        victim_req = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        n = 1;
        while (!victim_valid && n < 20) begin
            case (mode)
                1: begin
                    if (n == 2) begin
                        fill_valid = 1'b1;
                        fill_idx   = 3'd6;
                    end
                    if (n == 3 || n == 5) tick = 1'b1;
                    if (n == 4) begin
                        fill_valid = 1'b1;
                        fill_idx   = 3'd0;
                    end
                end
                2: begin
                    if (n == 2 || n == 5) victim_req = 1'b1;
                end
                default: ;
            endcase
            cycle();
            clr();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd9);
        check({tag, "_idx"}, 32'(victim_idx), 32'(eidx));
        check({tag, "_cnt"}, 32'(victim_cnt), 32'(ecnt));
        cycle();
        check({tag, "_pulse"}, 32'(victim_valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int hits [8];
        int nv;
        int first_v;
        int second_v;

        #2 rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(victim_valid), 32'd0);
        check("rst_idx", 32'(victim_idx), 32'd0);
        check("rst_cnt", 32'(victim_cnt), 32'd0);
        repeat (2) cycle();
        rst = 1'b1;
        repeat (5) cycle();
        for (int i = 0; i < 8; i++) chk_cnt(i, 0);
        scan(0, "empty", 0, 0);

        // basic LFU: entry 6 only filled
        for (int i = 0; i < 8; i++) fill(i);
        hit(3, 4);
        hit(5, 2);
        hit(0, 1);
        hit(1, 1);
        hit(2, 1);
        hit(4, 1);
        hit(7, 1);
        chk_cnt(3, 5);
        scan(0, "lfu", 6, 1);

        // -> [3,2,3,5,2,3,3,3], tie between 1 and 4
        hit(6, 2);
        hit(0, 1);
        hit(2, 1);
        hit(7, 1);
        scan(0, "tie", 1, 2);

        // saturation and aging
        hit(2, 300);
        chk_cnt(2, 255);
        tick = 1'b1;
        cycle();
        clr();
        chk_cnt(2, 127);
        chk_cnt(3, 2);
        tick      = 1'b1;
        hit_valid = 1'b1;
        hit_idx   = 3'd2;
        cycle();
        clr();
        chk_cnt(2, 64);
        tick = 1'b1;
        cycle();
        clr();
        chk_cnt(2, 32);
        chk_cnt(0, 0);
        chk_cnt(3, 0);

        // hit and fill on different entries, then fill beats hit+age
        hit_valid  = 1'b1;
        hit_idx    = 3'd2;
        fill_valid = 1'b1;
        fill_idx   = 3'd5;
        cycle();
        clr();
        chk_cnt(2, 33);
        chk_cnt(5, 1);
        tick       = 1'b1;
        hit_valid  = 1'b1;
        hit_idx    = 3'd3;
        fill_valid = 1'b1;
        fill_idx   = 3'd3;
        cycle();
        clr();
        chk_cnt(3, 1);
        chk_cnt(2, 16);
        chk_cnt(5, 0);

        // -> [5,3,6,4,7,8,9,10]; live fills and ticks during scan
        hits = '{4, 2, 5, 3, 6, 7, 8, 9};
        for (int i = 0; i < 8; i++) begin
            fill(i);
            hit(i, hits[i]);
        end
        chk_cnt(7, 10);
        scan(1, "tick_scan", 6, 1);
        chk_cnt(7, 10);
        cycle();
        chk_cnt(7, 5);
        chk_cnt(2, 3);
        chk_cnt(1, 1);
        chk_cnt(0, 0);

        // requests while busy are dropped
        scan(2, "busy_req", 0, 0);
        nv = 0;
        for (int e = 0; e < 15; e++) begin
            cycle();
            if (victim_valid) nv++;
        end
        check("busy_req_extra", 32'(nv), 32'd0);

        // level request: re-accepted in the IDLE cycle after DONE
        first_v    = 0;
        second_v   = 0;
        victim_req = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            cycle();
            if (victim_valid) begin
                if (first_v == 0) first_v = e;
                else if (second_v == 0) second_v = e;
            end
        end
        victim_req = 1'b0;
        check("level_first", 32'(first_v), 32'd9);
        check("level_second", 32'(second_v), 32'd19);
        repeat (12) cycle();

        // reset mid-scan aborts
        victim_req = 1'b1;
        cycle();
        victim_req = 1'b0;
        repeat (3) cycle();
        check("abort_busy_pre", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(victim_valid), 32'd0);
        cycle();
        rst = 1'b1;
        nv  = 0;
        for (int e = 0; e < 15; e++) begin
            cycle();
            if (victim_valid) nv++;
        end
        check("abort_no_valid", 32'(nv), 32'd0);
        chk_cnt(7, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/lfu_tracker.md
Name: lfu_tracker

Overview:
- Downstream consumer of the periodic one-cycle tick from the 1 Hz timer.
- Keeps one saturating use counter per cache entry. Hits increment the counter; fills load it to 1; each tick ages every counter by halving it.
- On request, a sequential scan picks the least-frequently-used entry as the eviction victim for the cache controller.

Parameters:
- ENTRIES, 8, number of tracked cache entries (≥2).
- IDX_W, 3, index width; must equal ceil(log2(ENTRIES)).
- CNT_W, 8, counter width; saturation value CNT_MAX = 2^CNT_W-1.

Ports:
- clock  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle aging pulse from the timer.
- hit_valid  in  1  access hit this cycle.
- hit_idx  in  IDX_W  entry hit.
- fill_valid  in  1  entry (re)filled this cycle.
- fill_idx  in  IDX_W  entry filled.
- victim_req  in  1  start victim search (pulse or level; sampled only in IDLE).
- busy  out  1  high while a scan is in progress.
- victim_valid  out  1  one-cycle pulse: victim_idx is a fresh result.
- victim_idx  out  IDX_W  selected victim; held until the next result.
- victim_cnt  out  CNT_W  counter value of the victim at selection.

Behaviour:
- Reset (rst=0, asynchronous): all counters 0, FSM=IDLE, busy=0, victim_valid=0, victim_idx=0, victim_cnt=0, age_pending=0.
- Reset mid-scan aborts the scan; no victim_valid is issued.

Counter update, per entry, per cycle, in priority order:
- fill: if fill_valid && fill_idx==i, cnt<=1. This overrides hit and aging for that entry.
- otherwise base = aging_now ? cnt>>1 : cnt.
- if hit_valid && hit_idx==i, cnt <= min(base+1, CNT_MAX); else cnt <= base.
- Example: tick and hit on the same entry with cnt=9 gives 5.
- Increment saturates at CNT_MAX; never wraps.
- Halving 0 stays 0.
- Indices ≥ ENTRIES on hit_idx/fill_idx are ignored with no side effect.
- Hit and fill to different entries in the same cycle both apply.

Aging:
- aging_now = (tick && FSM==IDLE) || (age_pending && FSM==IDLE).
- A tick in SCAN or DONE sets age_pending. The halving is applied in the first IDLE cycle, then age_pending clears.
- A second tick while age_pending=1 is dropped: only one halving per scan window.

FSM states: IDLE, SCAN, DONE.
- IDLE: busy=0. If victim_req=1, go to SCAN with scan_ptr=0, best_idx=0, best_cnt=CNT_MAX, first=1.
- SCAN: busy=1. Each cycle compares live cnt[scan_ptr]. It becomes the new best if first, or if cnt < best_cnt (strict, so ties keep the lower index). scan_ptr increments; after entry ENTRIES-1 go to DONE.
- DONE: victim_idx<=best_idx, victim_cnt<=best_cnt, victim_valid=1 for this single cycle, busy=0, then go to IDLE.
- Latency: victim_req sampled at edge k gives victim_valid high in cycle k+ENTRIES+1.
- Hits and fills during SCAN update counters immediately. An entry already passed is not revisited.
- victim_req while busy is ignored. No queuing.
- A new victim_req may be accepted in the IDLE cycle directly after DONE.

Decomposition:
- Package lfu_pkg holds:
  - state_t enum {IDLE, SCAN, DONE};
  - function sat_inc(cnt) and the constant derivation CNT_MAX;
  - default parameter constants shared with the timer and cache controller.
- Sub-module lfu_counter, instantiated once per entry:
  - inputs: clock, rst, load_one, age, inc;
  - output: cnt;
  - implements the priority fill > age-then-inc.
- The top contains the per-entry decode, age_pending logic and the scan FSM.

Test Plan:
- Reset then idle 5 cycles → all counters 0; victim_req → victim_valid at cycle +9, victim_idx=0, victim_cnt=0.
- Fill 0..7, hits: entry3 ×4, entry5 ×2, all others ×1 except entry6 → scan returns victim_idx=6, victim_cnt=1.
- 300 hits to entry2 (CNT_W=8) → cnt[2]=255 (no wrap); tick → 127; tick+hit same cycle → 64.
- Entries 1 and 4 both at minimum value 2 → victim_idx=1 (tie to lowest index).
- Tick at scan cycle 3 → result uses unaged values; halving seen in the first IDLE cycle; a second tick in the same scan is not applied twice.
- rst low at scan cycle 4 → busy=0 and no victim_valid ever; victim_req during busy produces exactly one victim_valid.
